// File: rtl/linescanner_acquisition_controller.sv
// Line-scan acquisition sequencer: arms capture per line, counts pixels, paces lines and frames.
// Outputs are registered from the next state, so they match the state they describe; start is ignored while busy.
module linescanner_acquisition_controller #(
  parameter int PIXELS_PER_LINE    = 1024,
  parameter int LINES_PER_FRAME    = 512,
  parameter int LINE_PERIOD_CLOCKS = 2000,
  parameter int TIMEOUT_CLOCKS     = 4095
) (
  input  logic        pixel_clock,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        continuous,
  input  logic        lval,
  input  logic        pixel_valid,
  output logic        capture_enable,
  output logic        busy,
  output logic        line_done,
  output logic        frame_done,
  output logic [15:0] line_index,
  output logic [15:0] pixel_count,
  output logic        error_pixel_count,
  output logic        error_timeout
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_LVAL,
    COUNT,
    LINE_END,
    WAIT_PERIOD
  } state_t;

  localparam logic [31:0] PERIOD_LAST = 32'(LINE_PERIOD_CLOCKS - 1);
  localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CLOCKS);
  localparam logic [15:0] PIX_EXPECT  = 16'(PIXELS_PER_LINE);
  localparam logic [15:0] LAST_LINE   = 16'(LINES_PER_FRAME - 1);

  state_t      state;
  state_t      state_nxt;
  logic        lval_d;
  logic        stop_pending;
  logic [31:0] period_cnt;
  logic [31:0] timeout_cnt;
  logic [31:0] timeout_inc;
  logic        lval_rise;
  logic        lval_fall;
  logic        stop_seen;
  logic        last_line;
  logic        timeout_hit;
  logic        start_accept;

  assign lval_rise    = lval & ~lval_d;
  assign lval_fall    = ~lval & lval_d;
  assign stop_seen    = stop_pending | stop;
  assign last_line    = (line_index == LAST_LINE);
  assign timeout_inc  = timeout_cnt + 32'd1;
  assign timeout_hit  = (timeout_inc >= TIMEOUT_LIM);
  assign start_accept = (state == IDLE) && (state_nxt == ARM);

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A line start seen in the same cycle as the timeout limit wins over the timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start && !stop) state_nxt = ARM;
      end
      ARM: begin
        state_nxt = WAIT_LVAL;
      end
      WAIT_LVAL: begin
        if (lval_rise)        state_nxt = COUNT;
        else if (timeout_hit) state_nxt = IDLE;
      end
      COUNT: begin
        if (lval_fall) state_nxt = LINE_END;
      end
      LINE_END: begin
        if (last_line) state_nxt = (continuous && !stop_seen) ? WAIT_PERIOD : IDLE;
        else           state_nxt = stop_seen ? IDLE : WAIT_PERIOD;
      end
      WAIT_PERIOD: begin
        if (stop_seen)                      state_nxt = IDLE;
        else if (period_cnt >= PERIOD_LAST) state_nxt = ARM;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      capture_enable <= 1'b0;
      busy           <= 1'b0;
      line_done      <= 1'b0;
      frame_done     <= 1'b0;
      lval_d         <= 1'b0;
      stop_pending   <= 1'b0;
    end else begin
      capture_enable <= (state_nxt == ARM) || (state_nxt == WAIT_LVAL) ||
                        (state_nxt == COUNT) || (state_nxt == LINE_END);
      busy           <= (state_nxt != IDLE);
      line_done      <= (state_nxt == LINE_END);
      frame_done     <= (state_nxt == LINE_END) && last_line;
      lval_d         <= lval;
      if (state_nxt == IDLE) begin
        stop_pending <= 1'b0;
      end else if (stop && ((state == ARM) || (state == WAIT_LVAL) ||
                            (state == COUNT) || (state == LINE_END))) begin
        stop_pending <= 1'b1;
      end
    end
  end

  // Period counter reads zero during ARM so successive ARMs sit LINE_PERIOD_CLOCKS apart.
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      period_cnt  <= '0;
      timeout_cnt <= '0;
    end else begin
      if (state_nxt == ARM) begin
        period_cnt <= '0;
      end else if ((state != IDLE) && (period_cnt != '1)) begin
        period_cnt <= period_cnt + 32'd1;
      end
      if (state == ARM) begin
        timeout_cnt <= '0;
      end else if (state == WAIT_LVAL) begin
        timeout_cnt <= timeout_inc;
      end
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      line_index  <= '0;
      pixel_count <= '0;
    end else begin
      if (start_accept) begin
        line_index <= '0;
      end else if (state == LINE_END) begin
        line_index <= last_line ? 16'd0 : line_index + 16'd1;
      end
      if ((state == WAIT_LVAL) && lval_rise) begin
        pixel_count <= '0;
      end else if ((state == COUNT) && pixel_valid && (pixel_count != 16'hFFFF)) begin
        pixel_count <= pixel_count + 16'd1;
      end
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      error_pixel_count <= 1'b0;
      error_timeout     <= 1'b0;
    end else if (start_accept) begin
      error_pixel_count <= 1'b0;
      error_timeout     <= 1'b0;
    end else begin
      if ((state == LINE_END) && (pixel_count != PIX_EXPECT)) error_pixel_count <= 1'b1;
      if ((state == WAIT_LVAL) && (state_nxt == IDLE))        error_timeout     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_linescanner_acquisition_controller.sv
// Randomized line/frame sessions checked against a per-line arithmetic model of the acquisition rules.
// Outputs are read 1 time unit after each rising edge; inputs driven there are sampled on the next edge.
module tb_linescanner_acquisition_controller;

  localparam int PPL = 24;
  localparam int LPF = 3;
  localparam int LPC = 80;
  localparam int TC  = 40;

  logic        pixel_clock = 1'b0;
  logic        reset       = 1'b1;
  logic        start       = 1'b0;
  logic        stop        = 1'b0;
  logic        continuous  = 1'b0;
  logic        lval        = 1'b0;
  logic        pixel_valid = 1'b0;
  logic        capture_enable;
  logic        busy;
  logic        line_done;
  logic        frame_done;
  logic [15:0] line_index;
  logic [15:0] pixel_count;
  logic        error_pixel_count;
  logic        error_timeout;

  always #5 pixel_clock = ~pixel_clock;

  linescanner_acquisition_controller #(
    .PIXELS_PER_LINE   (PPL),
    .LINES_PER_FRAME   (LPF),
    .LINE_PERIOD_CLOCKS(LPC),
    .TIMEOUT_CLOCKS    (TC)
  ) dut (
    .pixel_clock      (pixel_clock),
    .reset            (reset),
    .start            (start),
    .stop             (stop),
    .continuous       (continuous),
    .lval             (lval),
    .pixel_valid      (pixel_valid),
    .capture_enable   (capture_enable),
    .busy             (busy),
    .line_done        (line_done),
    .frame_done       (frame_done),
    .line_index       (line_index),
    .pixel_count      (pixel_count),
    .error_pixel_count(error_pixel_count),
    .error_timeout    (error_timeout)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_ld     = 0;
  int n_fd     = 0;
  int exp_line = 0;
  bit exp_err_pix = 1'b0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge pixel_clock);
    #1;
    cyc++;
    if (line_done)  n_ld++;
    if (frame_done) n_fd++;
  endtask

  // Entered in the ARM cycle; ends in the LINE_END cycle. len = ARM-to-LINE_END distance.
  task automatic do_line(input int npix, input bit inject_stop, output int len);
    int d, b, fall_pv, body_pix, stop_at, k;
    d        = int'($urandom_range(TC - 2, 1));
    fall_pv  = (npix > 0) ? int'($urandom_range(1, 0)) : 0;
    body_pix = npix - fall_pv;
    stop_at  = inject_stop ? int'($urandom_range(body_pix, 0)) : -1;
    b        = 0;
    lval = 1'b0; pixel_valid = 1'b0;
    repeat (d) tick();
    lval = 1'b1;
    tick();
    for (int p = 0; p < body_pix; p++) begin
      k = int'($urandom_range(2, 0));
      for (int g = 0; g < k; g++) begin
        pixel_valid = 1'b0;
        start = ($urandom_range(7, 0) == 0);
        tick();
        b++;
      end
      start = 1'b0;
      pixel_valid = 1'b1;
      stop = (p == stop_at);
      tick();
      b++;
      stop = 1'b0;
      pixel_valid = 1'b0;
    end
    start = 1'b0;
    lval = 1'b0;
    pixel_valid = (fall_pv != 0);
    stop = (stop_at == body_pix);
    tick();
    stop = 1'b0;
    pixel_valid = 1'b0;
    len = d + b + 2;
    check_val("line_done_at_end", line_done, 1);
    check_val("frame_done_at_end", frame_done, (exp_line == LPF - 1));
    check_val("pixel_count", pixel_count, npix);
    check_val("line_index_in_end", line_index, exp_line);
    check_val("capture_en_in_end", capture_enable, 1);
  endtask

  // end_mode: 0 natural frame end, 1 stop during last line, 2 stop in WAIT_PERIOD after last line.
  task automatic session(input bit cont, input int nlines, input int end_mode, input int short_line);
    int len, arm_cyc, want, npix;
    bit stopped, frame_end, to_idle;
    continuous = cont;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_line = 0;
    exp_err_pix = 1'b0;
    check_val("arm_capture_en", capture_enable, 1);
    check_val("arm_busy", busy, 1);
    check_val("arm_err_pix", error_pixel_count, 0);
    check_val("arm_err_timeout", error_timeout, 0);
    check_val("arm_line_index", line_index, 0);
    for (int i = 0; i < nlines; i++) begin
      arm_cyc = cyc;
      if (i == short_line)                npix = PPL - int'($urandom_range(4, 1));
      else if ($urandom_range(4, 0) == 0) npix = PPL - 2 + int'($urandom_range(4, 0));
      else                                npix = PPL;
      stopped = (end_mode == 1) && (i == nlines - 1);
      do_line(npix, stopped, len);
      frame_end   = (exp_line == LPF - 1);
      exp_err_pix = exp_err_pix | (npix != PPL);
      exp_line    = frame_end ? 0 : exp_line + 1;
      to_idle     = stopped || (frame_end && !cont);
      tick();
      check_val("line_done_one_cycle", line_done, 0);
      check_val("err_pix_after_line", error_pixel_count, exp_err_pix);
      check_val("line_index_after", line_index, exp_line);
      check_val("busy_after_line", busy, !to_idle);
      check_val("capture_en_after_line", capture_enable, 0);
      if (to_idle) break;
      if ((end_mode == 2) && (i == nlines - 1)) begin
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_val("stop_in_period_busy", busy, 0);
        check_val("stop_in_period_ce", capture_enable, 0);
        break;
      end
      while ((capture_enable == 1'b0) && (cyc - arm_cyc < LPC + 200)) tick();
      want = (len + 2 > LPC) ? len + 2 : LPC;
      check_val("arm_spacing", cyc - arm_cyc, want);
    end
    repeat (3) tick();
    check_val("idle_after_session", busy, 0);
    check_val("err_pix_sticky", error_pixel_count, exp_err_pix);
  endtask

  task automatic timeout_run();
    continuous = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("to_arm_ce", capture_enable, 1);
    lval = 1'b0;
    for (int j = 1; j <= TC; j++) begin
      stop = (j == 3);
      tick();
      stop = 1'b0;
    end
    check_val("to_still_waiting", capture_enable, 1);
    check_val("to_not_yet", error_timeout, 0);
    tick();
    check_val("to_flag", error_timeout, 1);
    check_val("to_capture_off", capture_enable, 0);
    check_val("to_busy_off", busy, 0);
  endtask

  task automatic check_reset_state(input string where);
    check_val({where, "_ce"}, capture_enable, 0);
    check_val({where, "_busy"}, busy, 0);
    check_val({where, "_line_done"}, line_done, 0);
    check_val({where, "_frame_done"}, frame_done, 0);
    check_val({where, "_line_index"}, line_index, 0);
    check_val({where, "_pixel_count"}, pixel_count, 0);
    check_val({where, "_err_pix"}, error_pixel_count, 0);
    check_val({where, "_err_to"}, error_timeout, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int ld0, fd0, nl, em, sl;
    reset = 1'b1;
    repeat (3) tick();
    check_reset_state("reset");
    reset = 1'b0;
    tick();
    check_val("idle_after_reset", busy, 0);

    // One clean single-shot frame.
    ld0 = n_ld; fd0 = n_fd;
    session(1'b0, LPF, 0, -1);
    check_val("frame_line_done_count", n_ld - ld0, LPF);
    check_val("frame_frame_done_count", n_fd - fd0, 1);

    // Frame with a short line; the error stays set through a rejected start.
    session(1'b0, LPF, 0, int'($urandom_range(LPF - 1, 0)));
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check_val("start_stop_idle", busy, 0);
    tick();
    check_val("start_stop_still_idle", busy, 0);
    check_val("start_stop_keeps_err", error_pixel_count, 1);

    timeout_run();

    for (int s = 0; s < 6; s++) begin
      nl = int'($urandom_range(7, 2));
      em = int'($urandom_range(2, 1));
      sl = ($urandom_range(1, 0) == 1) ? int'($urandom_range(nl - 1, 0)) : -1;
      ld0 = n_ld; fd0 = n_fd;
      session(1'b1, nl, em, sl);
      check_val("cont_line_done_count", n_ld - ld0, nl);
      check_val("cont_frame_done_count", n_fd - fd0, nl / LPF);
    end

    // Reset in the middle of a line.
    continuous = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    lval = 1'b0;
    repeat (3) tick();
    lval = 1'b1;
    tick();
    pixel_valid = 1'b1;
    repeat (5) tick();
    pixel_valid = 1'b0;
    check_val("midline_pixels", pixel_count, 5);
    lval = 1'b0;
    reset = 1'b1;
    ld0 = n_ld; fd0 = n_fd;
    tick();
    check_reset_state("midline_reset");
    reset = 1'b0;
    tick();
    check_val("midline_no_line_done", n_ld - ld0, 0);
    check_val("midline_no_frame_done", n_fd - fd0, 0);
    check_val("midline_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
